dmac_ctrl_unit: RTL and testbench
=================================

DMAC_CTRL_UNIT -- requirements
Module: dmac_ctrl_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: cycles allowed in XFER before abort; only used when DMAC_CTRL_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port DmacReq  in  2  peripheral request lines; bit1 = peripheral 2, bit0 = peripheral 1.
REQ-005 SHALL have port HReady  in  1  AHB ready for the current data phase.
REQ-006 SHALL have port M_HResp  in  2  AHB response; 00 = OKAY, any other value = error.
REQ-007 SHALL have port irq  in  1  channel transfer-complete pulse.
REQ-008 SHALL have port C_config  in  1  channel select from the loaded control word; 0 = channel 1, 1 = channel 2.
REQ-009 SHALL have output ports DmacReq_Reg_en and PeriAddr_reg_en  out  1  each; capture the request and the peripheral base.
REQ-010 SHALL have output ports SAddr_Reg_en, DAddr_Reg_en, Trans_sz_Reg_en and Ctrl_Reg_en  out  1  each; one-cycle config-register load strobes.
REQ-011 SHALL have port addr_inc_sel  out  2  config word index.
REQ-012 SHALL have port config_HTrans  out  2  HTRANS value for config fetch.
REQ-013 SHALL have port config_write  out  1  HWRITE value for config fetch.
REQ-014 SHALL have port con_sel  out  2  mux select; 00 = ch1, 01 = ch2, 10 = config.
REQ-015 SHALL have port con_en  out  1  strobe that latches con_sel.
REQ-016 SHALL have ports channel_en_1 and channel_en_2  out  1  each; channel enables.
REQ-017 SHALL have port busy  out  1  high in every state except IDLE.
REQ-018 SHALL have ports done and err  out  1  each; one-cycle completion and abort pulses.

Function
REQ-019 SHALL implement states IDLE, LATCH, CFG_A, CFG_D, SELECT, XFER, FINISH and ABORT.
REQ-020 In IDLE with DmacReq != 00, the FSM SHALL go to LATCH next cycle; with DmacReq = 00 it SHALL stay in IDLE.
REQ-021 In LATCH, DmacReq_Reg_en, PeriAddr_reg_en and con_en SHALL be 1 for exactly one cycle, with con_sel = 10; the next state SHALL be CFG_A with word index 0.
REQ-022 For DmacReq = 11, the grant SHALL go to peripheral 2 (bit1 priority); there is no preemption, and a later request waits until the FSM is back in IDLE.
REQ-023 In CFG_A, config_HTrans SHALL be 10 (NONSEQ), config_write SHALL be 0, con_sel SHALL be 10, addr_inc_sel SHALL equal the word index, and the next state SHALL be CFG_D.
REQ-024 In CFG_D, config_HTrans SHALL be 00; while HReady = 0 the FSM SHALL hold, with no strobes.
REQ-025 In CFG_D with HReady = 1 and M_HResp = 00, exactly one strobe SHALL fire for index 0..3: index 0 = SAddr, 1 = DAddr, 2 = Trans_sz, 3 = Ctrl.
REQ-026 After a strobe in CFG_D, the index SHALL increment and the FSM SHALL return to CFG_A, or go to SELECT after index 3; the 2-bit index SHALL NOT wrap within a request.
REQ-027 In CFG_D with HReady = 1 and M_HResp != 00, no strobe SHALL fire and the next state SHALL be ABORT.
REQ-028 In SELECT, con_sel SHALL be {1'b0, C_config} with con_en = 1 for one cycle, and the next state SHALL be XFER.
REQ-029 In XFER, channel_en_1 SHALL equal !C_config and channel_en_2 SHALL equal C_config; exactly one enable SHALL be high, held until exit.
REQ-030 In XFER, irq = 1 SHALL move the FSM to FINISH, and both enables SHALL be 0 in FINISH.
REQ-031 If irq and an error response (HReady = 1, M_HResp != 00) occur in the same XFER cycle, the error SHALL win and the next state SHALL be ABORT.
REQ-032 FINISH SHALL pulse done = 1 for one cycle and then return to IDLE; a held request SHALL be re-arbitrated from IDLE.
REQ-033 ABORT SHALL pulse err = 1 for one cycle, force all enables and strobes to 0, and then return to IDLE.
REQ-034 Outside the states named above, all strobes, con_en, channel enables and config_HTrans SHALL be 0.

Reset
REQ-035 While rst = 0, the FSM SHALL be in IDLE and the word index and timeout counter SHALL be 0.
REQ-036 While rst = 0, every output SHALL be 0, including con_sel = 00 and addr_inc_sel = 00.
REQ-037 Reset asserted mid-transfer SHALL drop channel enables asynchronously, with no done or err pulse.

Configuration
REQ-038 With DMAC_CTRL_TIMEOUT_EN defined, a counter SHALL clear on XFER entry and increment each XFER cycle, and reaching TIMEOUT_CYCLES - 1 without irq SHALL force ABORT.
REQ-039 Without DMAC_CTRL_TIMEOUT_EN, no counter SHALL exist and XFER SHALL wait indefinitely for irq.

Verification
REQ-040 The bench SHALL check: DmacReq = 01, HReady = 1, OKAY, C_config = 0, irq after 20 cycles -> strobes in order SAddr, DAddr, Trans_sz, Ctrl on cycles 3, 5, 7, 9 after the request; channel_en_1 = 1; done one cycle after irq.
REQ-041 The bench SHALL check: DmacReq = 11 -> DmacReq_Reg_en pulse in LATCH, C_config = 1 -> con_sel = 01 and channel_en_2 = 1.
REQ-042 The bench SHALL check: HReady = 0 for 3 cycles in word 2 data phase -> Trans_sz_Reg_en is delayed 3 cycles and fires once.
REQ-043 The bench SHALL check: M_HResp = 01 on word 1 -> no DAddr_Reg_en, err pulse, busy = 0 two cycles later.
REQ-044 The bench SHALL check: with DMAC_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES = 8 and no irq -> ABORT after 8 XFER cycles with err = 1.
REQ-045 The bench SHALL check: rst = 0 during XFER -> channel_en_1 = 0 immediately, with no done or err.

Source files
------------

// File: rtl/dmac_ctrl_unit_if.sv
// dmac_ctrl_unit_if: request/AHB status in, config strobes and channel
// enables out; master = controller, slave = datapath/bench side.
interface dmac_ctrl_unit_if;
  logic [1:0] DmacReq;
  logic       HReady;
  logic [1:0] M_HResp;
  logic       irq;
  logic       C_config;
  logic       DmacReq_Reg_en;
  logic       PeriAddr_reg_en;
  logic       SAddr_Reg_en;
  logic       DAddr_Reg_en;
  logic       Trans_sz_Reg_en;
  logic       Ctrl_Reg_en;
  logic [1:0] addr_inc_sel;
  logic [1:0] config_HTrans;
  logic       config_write;
  logic [1:0] con_sel;
  logic       con_en;
  logic       channel_en_1;
  logic       channel_en_2;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    input  DmacReq, HReady, M_HResp,
    input  irq, C_config,
    output DmacReq_Reg_en, PeriAddr_reg_en,
    output SAddr_Reg_en, DAddr_Reg_en,
    output Trans_sz_Reg_en, Ctrl_Reg_en,
    output addr_inc_sel, config_HTrans,
    output config_write, con_sel, con_en,
    output channel_en_1, channel_en_2,
    output busy, done, err
  );

  modport slave (
    output DmacReq, HReady, M_HResp,
    output irq, C_config,
    input  DmacReq_Reg_en, PeriAddr_reg_en,
    input  SAddr_Reg_en, DAddr_Reg_en,
    input  Trans_sz_Reg_en, Ctrl_Reg_en,
    input  addr_inc_sel, config_HTrans,
    input  config_write, con_sel, con_en,
    input  channel_en_1, channel_en_2,
    input  busy, done, err
  );
endinterface

// File: rtl/dmac_ctrl_unit.sv
// dmac_ctrl_unit: DMA control FSM (latch, 4-word config fetch, select, xfer).
// Define DMAC_CTRL_TIMEOUT_EN to enable the XFER watchdog (TIMEOUT_CYCLES).
module dmac_ctrl_unit #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic              clk,
  input logic              rst,
  dmac_ctrl_unit_if.master bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LATCH  = 3'd1;
  localparam logic [2:0] CFG_A  = 3'd2;
  localparam logic [2:0] CFG_D  = 3'd3;
  localparam logic [2:0] SELECT = 3'd4;
  localparam logic [2:0] XFER   = 3'd5;
  localparam logic [2:0] FINISH = 3'd6;
  localparam logic [2:0] ABORT  = 3'd7;

  logic [2:0] state;
  logic [2:0] nxt;
  logic [1:0] idx;
  logic       hs_err;
  logic       hs_ok;
  logic       tmo;

  assign hs_err = bus.HReady && (bus.M_HResp != 2'b00);
  assign hs_ok  = bus.HReady && (bus.M_HResp == 2'b00);

`ifdef DMAC_CTRL_TIMEOUT_EN
  localparam int CW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt;

  // Held at zero outside XFER, so it restarts on every XFER entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (state != XFER)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  assign tmo = (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      idx   <= 2'd0;
    end else begin
      state <= nxt;
      if (state == LATCH)
        idx <= 2'd0;
      else if (state == CFG_D && hs_ok && idx != 2'd3)
        idx <= idx + 2'd1;
    end
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   if (bus.DmacReq != 2'b00) nxt = LATCH;
      LATCH:  nxt = CFG_A;
      CFG_A:  nxt = CFG_D;
      CFG_D: begin
        if (hs_err)
          nxt = ABORT;
        else if (hs_ok)
          nxt = (idx == 2'd3) ? SELECT : CFG_A;
      end
      SELECT: nxt = XFER;
      // Bus error beats irq; irq beats the watchdog.
      XFER: begin
        if (hs_err)
          nxt = ABORT;
        else if (bus.irq)
          nxt = FINISH;
        else if (tmo)
          nxt = ABORT;
      end
      FINISH: nxt = IDLE;
      ABORT:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.DmacReq_Reg_en  = 1'b0;
    bus.PeriAddr_reg_en = 1'b0;
    bus.SAddr_Reg_en    = 1'b0;
    bus.DAddr_Reg_en    = 1'b0;
    bus.Trans_sz_Reg_en = 1'b0;
    bus.Ctrl_Reg_en     = 1'b0;
    bus.addr_inc_sel    = 2'b00;
    bus.config_HTrans   = 2'b00;
    bus.config_write    = 1'b0;
    bus.con_sel         = 2'b00;
    bus.con_en          = 1'b0;
    bus.channel_en_1    = 1'b0;
    bus.channel_en_2    = 1'b0;
    bus.busy            = (state != IDLE);
    bus.done            = 1'b0;
    bus.err             = 1'b0;
    unique case (state)
      LATCH: begin
        bus.DmacReq_Reg_en  = 1'b1;
        bus.PeriAddr_reg_en = 1'b1;
        bus.con_en          = 1'b1;
        bus.con_sel         = 2'b10;
      end
      CFG_A: begin
        bus.config_HTrans = 2'b10;
        bus.con_sel       = 2'b10;
        bus.addr_inc_sel  = idx;
      end
      CFG_D: begin
        bus.con_sel         = 2'b10;
        bus.addr_inc_sel    = idx;
        bus.SAddr_Reg_en    = hs_ok && (idx == 2'd0);
        bus.DAddr_Reg_en    = hs_ok && (idx == 2'd1);
        bus.Trans_sz_Reg_en = hs_ok && (idx == 2'd2);
        bus.Ctrl_Reg_en     = hs_ok && (idx == 2'd3);
      end
      SELECT: begin
        bus.con_sel = {1'b0, bus.C_config};
        bus.con_en  = 1'b1;
      end
      XFER: begin
        bus.con_sel      = {1'b0, bus.C_config};
        bus.channel_en_1 = !bus.C_config;
        bus.channel_en_2 = bus.C_config;
      end
      FINISH: bus.done = 1'b1;
      ABORT:  bus.err  = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dmac_ctrl_unit.sv
// tb_dmac_ctrl_unit: scoreboard bench for dmac_ctrl_unit.
// Expected strobe/done/err pulses are queued with their cycle.
module tb_dmac_ctrl_unit;
  localparam logic [6:0] E_RQ = 7'h01;
  localparam logic [6:0] E_SA = 7'h02;
  localparam logic [6:0] E_DA = 7'h04;
  localparam logic [6:0] E_TS = 7'h08;
  localparam logic [6:0] E_CT = 7'h10;
  localparam logic [6:0] E_DN = 7'h20;
  localparam logic [6:0] E_ER = 7'h40;

  typedef struct {
    string      tag;
    int         cyc;
    logic [6:0] code;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   base;
  int   n_chk;
  int   n_pass;
  exp_t sb[$];

  dmac_ctrl_unit_if bus();

  dmac_ctrl_unit #(
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_to(input int rel);
    while (cyc < base + rel) tick();
  endtask

  task automatic exp_ev(input string tag,
                        input int rel,
                        input logic [6:0] code);
    sb.push_back('{tag, base + rel, code});
  endtask

  task automatic exp_cfg(input string p, input int hold);
    exp_ev({p, "_req"}, 1, E_RQ);
    exp_ev({p, "_sa"}, 3, E_SA);
    exp_ev({p, "_da"}, 5, E_DA);
    exp_ev({p, "_ts"}, 7 + hold, E_TS);
    exp_ev({p, "_ct"}, 9 + hold, E_CT);
  endtask

  task automatic start(input logic [1:0] req, input logic cc);
    tick();
    base = cyc;
    bus.C_config = cc;
    bus.DmacReq  = req;
  endtask

  // Every pulse must match the head of the scoreboard, in value and cycle.
  always @(negedge clk) begin
    logic [6:0] ev;
    exp_t       e;
    ev = {bus.err, bus.done, bus.Ctrl_Reg_en,
          bus.Trans_sz_Reg_en, bus.DAddr_Reg_en,
          bus.SAddr_Reg_en, bus.DmacReq_Reg_en};
    if (ev != 7'd0) begin
      if (sb.size() == 0) begin
        check("spurious_pulse", 32'(ev), 32'd0);
      end else begin
        e = sb.pop_front();
        check(e.tag, 32'(ev), 32'(e.code));
        check({e.tag, "_cyc"}, cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    n_chk  = 0;
    n_pass = 0;
    base   = 0;
    rst    = 1'b0;
    bus.DmacReq  = 2'b00;
    bus.HReady   = 1'b1;
    bus.M_HResp  = 2'b00;
    bus.irq      = 1'b0;
    bus.C_config = 1'b0;
    repeat (3) tick();
    check("rst_out",
          {bus.DmacReq_Reg_en, bus.PeriAddr_reg_en,
           bus.SAddr_Reg_en, bus.DAddr_Reg_en,
           bus.Trans_sz_Reg_en, bus.Ctrl_Reg_en,
           bus.con_en, bus.channel_en_1,
           bus.channel_en_2, bus.busy, bus.done,
           bus.err, bus.config_write}, 0);
    check("rst_sel",
          {bus.con_sel, bus.addr_inc_sel,
           bus.config_HTrans}, 0);
    rst = 1'b1;
    repeat (2) tick();
    check("idle_busy", bus.busy, 0);

    // Channel 1, all OKAY, irq in cycle 20
    start(2'b01, 1'b0);
    exp_cfg("t1", 0);
    exp_ev("t1_done", 21, E_DN);
    go_to(1);
    check("t1_latch_sel", bus.con_sel, 2'b10);
    check("t1_latch_en", {bus.con_en, bus.PeriAddr_reg_en}, 2'b11);
    bus.DmacReq = 2'b00;
    go_to(10);
    check("t1_sel", {bus.con_en, bus.con_sel}, 3'b100);
    go_to(15);
    check("t1_en", {bus.channel_en_1, bus.channel_en_2}, 2'b10);
    go_to(20);
    bus.irq = 1'b1;
    go_to(21);
    bus.irq = 1'b0;
    check("t1_fin_en", {bus.channel_en_1, bus.channel_en_2}, 0);
    go_to(23);
    check("t1_idle", bus.busy, 0);
    check("t1_drain", sb.size(), 0);

    // Both requests, channel 2 selected
    start(2'b11, 1'b1);
    exp_cfg("t2", 0);
    exp_ev("t2_done", 15, E_DN);
    go_to(1);
    bus.DmacReq = 2'b00;
    go_to(10);
    check("t2_sel", {bus.con_en, bus.con_sel}, 3'b101);
    go_to(12);
    check("t2_en", {bus.channel_en_1, bus.channel_en_2}, 2'b01);
    go_to(14);
    bus.irq = 1'b1;
    go_to(15);
    bus.irq = 1'b0;
    go_to(17);
    check("t2_drain", sb.size(), 0);

    // Wait states on word 2 data phase
    start(2'b01, 1'b0);
    exp_cfg("t3", 3);
    exp_ev("t3_done", 17, E_DN);
    go_to(1);
    bus.DmacReq = 2'b00;
    go_to(6);
    check("t3_htrans_a", bus.config_HTrans, 2'b10);
    check("t3_idx", bus.addr_inc_sel, 2'd2);
    check("t3_write", bus.config_write, 0);
    go_to(7);
    bus.HReady = 1'b0;
    go_to(8);
    check("t3_htrans_d", bus.config_HTrans, 2'b00);
    go_to(10);
    bus.HReady = 1'b1;
    go_to(16);
    bus.irq = 1'b1;
    go_to(17);
    bus.irq = 1'b0;
    go_to(19);
    check("t3_drain", sb.size(), 0);

    // Error response on word 1
    start(2'b01, 1'b0);
    exp_ev("t4_req", 1, E_RQ);
    exp_ev("t4_sa", 3, E_SA);
    exp_ev("t4_err", 6, E_ER);
    go_to(1);
    bus.DmacReq = 2'b00;
    go_to(5);
    bus.M_HResp = 2'b01;
    go_to(6);
    bus.M_HResp = 2'b00;
    check("t4_busy_abort", bus.busy, 1);
    go_to(7);
    check("t4_busy_idle", bus.busy, 0);
    go_to(9);
    check("t4_drain", sb.size(), 0);

    // irq and error in the same XFER cycle
    start(2'b10, 1'b0);
    exp_cfg("t5", 0);
    exp_ev("t5_err", 14, E_ER);
    go_to(1);
    bus.DmacReq = 2'b00;
    go_to(13);
    bus.irq     = 1'b1;
    bus.M_HResp = 2'b10;
    go_to(14);
    bus.irq     = 1'b0;
    bus.M_HResp = 2'b00;
    go_to(16);
    check("t5_drain", sb.size(), 0);

`ifdef DMAC_CTRL_TIMEOUT_EN
    // No irq: watchdog aborts after 8 XFER cycles
    start(2'b01, 1'b0);
    exp_cfg("t6", 0);
    exp_ev("t6_err", 19, E_ER);
    go_to(1);
    bus.DmacReq = 2'b00;
    go_to(18);
    check("t6_en_last", bus.channel_en_1, 1);
    go_to(21);
    check("t6_drain", sb.size(), 0);
`endif

    // Reset during XFER
    start(2'b01, 1'b0);
    exp_cfg("t7", 0);
    go_to(1);
    bus.DmacReq = 2'b00;
    go_to(15);
    check("t7_en_pre", bus.channel_en_1, 1);
    rst = 1'b0;
    #1;
    check("t7_en_rst", {bus.channel_en_1, bus.busy}, 0);
    check("t7_sel_rst", bus.con_sel, 0);
    repeat (2) tick();
    rst = 1'b1;
    go_to(22);
    check("t7_idle", bus.busy, 0);
    check("t7_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
